// File: rtl/cbb_dmux_rxbuf.sv
// cbb_dmux_rxbuf: receive buffer behind a CDC DMUX destination.
// Turns the DMUX's valid pulses or levels into words in a small
// first-word-fall-through FIFO. The consumer side uses a ready/valid
// handshake. The upstream side has no ready signal, so a word that
// arrives when the buffer is full is dropped and flagged on o_overflow.
//
// Handshake: a word transfers on the consumer side in any cycle where
// o_valid and i_ready are both 1 at the rising edge of i_clk. o_valid
// never depends on i_ready. o_data holds the oldest stored word whenever
// o_valid is 1.
module cbb_dmux_rxbuf #(
  parameter int    P_DATA_WIDTH  = 16,
  parameter int    P_DEPTH       = 4,
  parameter string P_TIMING_MODE = "DATA_VALID-ALIGN"
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [P_DATA_WIDTH-1:0]    i_data,
  output logic                       o_valid,
  output logic [P_DATA_WIDTH-1:0]    o_data,
  input  logic                       i_ready,
  output logic [$clog2(P_DEPTH):0]   o_count,
  output logic                       o_full,
  output logic                       o_overflow,
  input  logic                       i_clr_ovf
);

  localparam int LP_AW = $clog2(P_DEPTH);
  localparam int LP_CW = LP_AW + 1;
  // Any mode other than "DATA_VALID-1" captures on the rising edge of i_valid.
  localparam bit LP_ALIGN = (P_TIMING_MODE != "DATA_VALID-1");
  localparam logic [LP_CW-1:0] LP_DEPTH_C = LP_CW'(P_DEPTH);

  // Storage is never reset. Its contents are don't-care until written.
  logic [P_DATA_WIDTH-1:0] r_mem [P_DEPTH];
  logic [LP_AW-1:0]        r_wptr;
  logic [LP_AW-1:0]        r_rptr;
  logic [LP_CW-1:0]        r_count;
  logic                    r_overflow;
  // The previous i_valid resets to 1. In ALIGN mode, a level that is
  // already high when reset is released is therefore not mistaken for
  // a rising edge.
  logic                    r_valid_d;

  logic w_event;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Decode capture, push, pop and drop from registered state and the inputs.
  always_comb begin
    w_event = 1'b0;
    if (LP_ALIGN) begin
      w_event = i_valid & ~r_valid_d;
    end else begin
      w_event = i_valid;
    end
    w_full  = (r_count == LP_DEPTH_C);
    w_empty = (r_count == '0);
    w_pop   = ~w_empty & i_ready;
    // A pop in the same cycle frees a slot, so a full buffer can still
    // accept the new word.
    w_push  = w_event & (~w_full | w_pop);
    w_drop  = w_event & w_full & ~w_pop;
  end

  // Register the previous i_valid level for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid_d <= 1'b1;
    end else begin
      r_valid_d <= i_valid;
    end
  end

  // Write the captured word at the write pointer. The memory has no reset.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Advance the pointers. Power-of-two depth makes wrap to 0 natural.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + LP_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + LP_AW'(1);
      end
    end
  end

  // Track occupancy. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CW'(1);
        2'b01:   r_count <= r_count - LP_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag. A new drop takes priority over a clear in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  // Drive the outputs. The status outputs are decodes of registered
  // state; o_data is a fall-through read of the head slot.
  always_comb begin
    o_valid    = ~w_empty;
    o_full     = w_full;
    o_count    = r_count;
    o_overflow = r_overflow;
    o_data     = r_mem[r_rptr];
  end

endmodule

// File: tb/tb_cbb_dmux_rxbuf.sv
// Testbench for cbb_dmux_rxbuf. It uses two instances that share the
// clock and reset: u_dut_a runs in "DATA_VALID-ALIGN" mode and u_dut_v
// runs in "DATA_VALID-1" mode, both with P_DEPTH = 4. A queue-based
// reference model tracks each instance cycle by cycle.
module tb_cbb_dmux_rxbuf;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  // ALIGN-mode instance signals
  logic          a_valid, a_ready, a_clr;
  logic [DW-1:0] a_data;
  logic          a_ovalid, a_full, a_ovf;
  logic [DW-1:0] a_odata;
  logic [CW-1:0] a_count;

  // VALID-1-mode instance signals
  logic          v_valid, v_ready, v_clr;
  logic [DW-1:0] v_data;
  logic          v_ovalid, v_full, v_ovf;
  logic [DW-1:0] v_odata;
  logic [CW-1:0] v_count;

  cbb_dmux_rxbuf #(.P_DATA_WIDTH(DW), .P_DEPTH(DEPTH), .P_TIMING_MODE("DATA_VALID-ALIGN")) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .i_data(a_data),
    .o_valid(a_ovalid), .o_data(a_odata), .i_ready(a_ready),
    .o_count(a_count), .o_full(a_full), .o_overflow(a_ovf), .i_clr_ovf(a_clr)
  );

  cbb_dmux_rxbuf #(.P_DATA_WIDTH(DW), .P_DEPTH(DEPTH), .P_TIMING_MODE("DATA_VALID-1")) u_dut_v (
    .i_clk(clk), .i_rst(rst), .i_valid(v_valid), .i_data(v_data),
    .o_valid(v_ovalid), .o_data(v_odata), .i_ready(v_ready),
    .o_count(v_count), .o_full(v_full), .o_overflow(v_ovf), .i_clr_ovf(v_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per instance, the overflow flag and the previous valid level
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic          m_ovf[2];
  logic          m_prev[2];

  // Apply one clock edge to the model, using the inputs currently driven
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic          vld, rdy, clr;
      logic [DW-1:0] d;
      int            sz;
      bit            ev, pop, full, drop;
      vld = (k == 0) ? a_valid : v_valid;
      rdy = (k == 0) ? a_ready : v_ready;
      clr = (k == 0) ? a_clr   : v_clr;
      d   = (k == 0) ? a_data  : v_data;
      sz  = (k == 0) ? exp_q0.size() : exp_q1.size();
      if (rst) begin
        if (k == 0) exp_q0.delete(); else exp_q1.delete();
        m_ovf[k]  = 1'b0;
        m_prev[k] = 1'b1;
      end else begin
        ev   = (k == 0) ? (vld && !m_prev[k]) : vld;
        pop  = (sz != 0) && rdy;
        full = (sz == DEPTH);
        drop = ev && full && !pop;
        if (pop) begin
          if (k == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
        end
        if (ev && !drop) begin
          if (k == 0) exp_q0.push_back(d); else exp_q1.push_back(d);
        end
        if (drop) m_ovf[k] = 1'b1;
        else if (clr) m_ovf[k] = 1'b0;
        m_prev[k] = vld;
      end
    end
  endtask

  // Driver: advance the model and one clock, then return at the negedge for sampling and driving
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_a(input logic [DW-1:0] d);
    a_valid = 1'b1; a_data = d; step();
    a_valid = 1'b0; step();
  endtask

  task automatic pulse_v(input logic [DW-1:0] d);
    v_valid = 1'b1; v_data = d; step();
    v_valid = 1'b0; step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_tests++; if (a_ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid got %b exp 0", a_ovalid); end
    n_tests++; if (a_count !== 0) begin n_fail++; $display("FAIL reset_a_count got %0d exp 0", a_count); end
    n_tests++; if (a_full !== 1'b0) begin n_fail++; $display("FAIL reset_a_full got %b exp 0", a_full); end
    n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_a_ovf got %b exp 0", a_ovf); end
    n_tests++; if (v_ovalid !== 1'b0 || v_count !== 0) begin n_fail++; $display("FAIL reset_v_state got valid=%b count=%0d exp 0/0", v_ovalid, v_count); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_align_long();
    a_valid = 1'b1; a_data = 16'h5A5A; a_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    n_tests++; if (a_count !== 1) begin n_fail++; $display("FAIL align_long_count got %0d exp 1", a_count); end
    n_tests++; if (a_ovalid !== 1'b1 || a_odata !== 16'h5A5A) begin n_fail++; $display("FAIL align_long_data got valid=%b data=%h exp 1/5a5a", a_ovalid, a_odata); end
    a_valid = 1'b0; a_ready = 1'b1; step();
    a_ready = 1'b0;
    n_tests++; if (a_count !== 0) begin n_fail++; $display("FAIL align_long_drain got %0d exp 0", a_count); end
  endtask

  task automatic test_valid1_pulses();
    logic [DW-1:0] exp_w;
    pulse_v(16'h0001); pulse_v(16'h0002); pulse_v(16'h0003);
    n_tests++; if (v_count !== 3) begin n_fail++; $display("FAIL v1_count got %0d exp 3", v_count); end
    v_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_w = DW'(i);
      n_tests++; if (v_ovalid !== 1'b1 || v_odata !== exp_w) begin n_fail++; $display("FAIL v1_read%0d got valid=%b data=%h exp 1/%h", i, v_ovalid, v_odata, exp_w); end
      step();
    end
    v_ready = 1'b0;
    n_tests++; if (v_count !== 0 || v_ovalid !== 1'b0) begin n_fail++; $display("FAIL v1_empty got count=%0d valid=%b exp 0/0", v_count, v_ovalid); end
    // A level held high in this mode captures once per cycle
    v_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin v_data = DW'(16'h0007 + i); step(); end
    v_valid = 1'b0;
    n_tests++; if (v_count !== 3 || v_odata !== 16'h0007) begin n_fail++; $display("FAIL v1_level got count=%0d data=%h exp 3/0007", v_count, v_odata); end
    v_ready = 1'b1; step(); step(); step(); v_ready = 1'b0;
    n_tests++; if (v_count !== 0) begin n_fail++; $display("FAIL v1_level_drain got %0d exp 0", v_count); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_w;
    for (int i = 1; i <= 5; i++) pulse_a(DW'(i));
    n_tests++; if (a_full !== 1'b1 || a_count !== 4) begin n_fail++; $display("FAIL ovf_full got full=%b count=%0d exp 1/4", a_full, a_count); end
    n_tests++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", a_ovf); end
    a_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_w = DW'(i);
      n_tests++; if (a_ovalid !== 1'b1 || a_odata !== exp_w) begin n_fail++; $display("FAIL ovf_read%0d got valid=%b data=%h exp 1/%h", i, a_ovalid, a_odata, exp_w); end
      step();
    end
    a_ready = 1'b0;
    n_tests++; if (a_count !== 0 || a_ovalid !== 1'b0 || a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_after got count=%0d valid=%b ovf=%b exp 0/0/1", a_count, a_ovalid, a_ovf); end
  endtask

  task automatic test_clr_ovf();
    a_clr = 1'b1; step(); a_clr = 1'b0;
    n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_plain got %b exp 0", a_ovf); end
    for (int i = 0; i < 4; i++) pulse_a(DW'(16'h0020 + i));
    a_valid = 1'b1; a_data = 16'h0024; a_clr = 1'b1; step();
    a_valid = 1'b0; a_clr = 1'b0;
    n_tests++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL clr_vs_drop got %b exp 1", a_ovf); end
    n_tests++; if (a_count !== 4 || a_odata !== 16'h0020) begin n_fail++; $display("FAIL clr_drop_contents got count=%0d data=%h exp 4/0020", a_count, a_odata); end
    a_clr = 1'b1; step(); a_clr = 1'b0;
    n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_again got %b exp 0", a_ovf); end
    a_ready = 1'b1; for (int i = 0; i < 4; i++) step(); a_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [DW-1:0] exp_w;
    for (int i = 0; i < 4; i++) pulse_a(DW'(16'h0010 + i));
    a_valid = 1'b1; a_data = 16'h0014; a_ready = 1'b1; step();
    a_valid = 1'b0; a_ready = 1'b0;
    n_tests++; if (a_count !== 4 || a_full !== 1'b1) begin n_fail++; $display("FAIL fullpop_count got count=%0d full=%b exp 4/1", a_count, a_full); end
    n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf got %b exp 0", a_ovf); end
    step(); // a_valid falls, arming the next rising edge
    a_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_w = DW'(16'h0010 + i);
      n_tests++; if (a_ovalid !== 1'b1 || a_odata !== exp_w) begin n_fail++; $display("FAIL fullpop_read%0d got data=%h exp %h", i, a_odata, exp_w); end
      step();
    end
    a_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_a(16'h0030); pulse_a(16'h0031);
    a_valid = 1'b1; a_data = 16'h0032; step();
    n_tests++; if (a_count !== 3) begin n_fail++; $display("FAIL rstmid_pre got %0d exp 3", a_count); end
    rst = 1'b1; step(); rst = 1'b0;
    n_tests++; if (a_count !== 0 || a_ovalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear got count=%0d valid=%b exp 0/0", a_count, a_ovalid); end
    step(); step(); step();
    n_tests++; if (a_count !== 0) begin n_fail++; $display("FAIL rstmid_held got %0d exp 0", a_count); end
    a_valid = 1'b0; step();
    a_valid = 1'b1; a_data = 16'h0033; step();
    a_valid = 1'b0;
    n_tests++; if (a_count !== 1 || a_odata !== 16'h0033) begin n_fail++; $display("FAIL rstmid_recap got count=%0d data=%h exp 1/0033", a_count, a_odata); end
    a_ready = 1'b1; step(); a_ready = 1'b0;
  endtask

  task automatic test_random();
    int rd_pct;
    for (int c = 0; c < 400; c++) begin
      rd_pct  = (c < 200) ? 20 : 70;
      rst     = ($urandom_range(0, 149) == 0);
      a_valid = ($urandom_range(0, 1) == 1);
      a_data  = DW'($urandom);
      a_ready = ($urandom_range(0, 99) < rd_pct);
      a_clr   = ($urandom_range(0, 11) == 0);
      v_valid = ($urandom_range(0, 2) != 0);
      v_data  = DW'($urandom);
      v_ready = ($urandom_range(0, 99) < rd_pct);
      v_clr   = ($urandom_range(0, 11) == 0);
      step();
      n_tests++;
      if (a_count !== exp_q0.size() || a_ovalid !== (exp_q0.size() != 0) ||
          a_full !== (exp_q0.size() == DEPTH) || a_ovf !== m_ovf[0] ||
          (exp_q0.size() != 0 && a_odata !== exp_q0[0])) begin
        n_fail++;
        $display("FAIL rand_a cyc %0d got count=%0d valid=%b full=%b ovf=%b data=%h exp count=%0d ovf=%b data=%h",
                 c, a_count, a_ovalid, a_full, a_ovf, a_odata, exp_q0.size(), m_ovf[0],
                 (exp_q0.size() != 0) ? exp_q0[0] : '0);
      end
      n_tests++;
      if (v_count !== exp_q1.size() || v_ovalid !== (exp_q1.size() != 0) ||
          v_full !== (exp_q1.size() == DEPTH) || v_ovf !== m_ovf[1] ||
          (exp_q1.size() != 0 && v_odata !== exp_q1[0])) begin
        n_fail++;
        $display("FAIL rand_v cyc %0d got count=%0d valid=%b full=%b ovf=%b data=%h exp count=%0d ovf=%b data=%h",
                 c, v_count, v_ovalid, v_full, v_ovf, v_odata, exp_q1.size(), m_ovf[1],
                 (exp_q1.size() != 0) ? exp_q1[0] : '0);
      end
    end
    rst = 1'b0;
    a_valid = 1'b0; a_ready = 1'b0; a_clr = 1'b0;
    v_valid = 1'b0; v_ready = 1'b0; v_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_data = '0; a_ready = 1'b0; a_clr = 1'b0;
    v_valid = 1'b0; v_data = '0; v_ready = 1'b0; v_clr = 1'b0;
    m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
    m_prev[0] = 1'b1; m_prev[1] = 1'b1;
    @(negedge clk);
    test_reset();
    test_align_long();
    test_valid1_pulses();
    test_overflow();
    test_clr_ovf();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cbb_dmux_rxbuf.md
CBB_DMUX_RXBUF -- requirements
Module: cbb_dmux_rxbuf

Interface
REQ-001 The block SHALL have parameter P_DATA_WIDTH, default 16, giving the data word width.
REQ-002 The block SHALL have parameter P_DEPTH, default 4, giving the buffer depth in words; legal values are powers of two, 2 or more.
REQ-003 The block SHALL have parameter P_TIMING_MODE, default "DATA_VALID-ALIGN", selecting the input capture rule; legal values are "DATA_VALID-1" and "DATA_VALID-ALIGN".
REQ-004 The block SHALL have one clock and synchronous, active-high reset: i_clk and i_rst, with no other clock or reset.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; it is the CDC destination clock.
REQ-006 The block SHALL have port i_rst, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port i_valid, input, 1 bit: valid from the upstream CDC DMUX destination side.
REQ-008 The block SHALL have port i_data, input, P_DATA_WIDTH bits: data from the upstream CDC DMUX; stable while i_valid is high.
REQ-009 The block SHALL have port o_valid, output, 1 bit: the buffer head word is available.
REQ-010 The block SHALL have port o_data, output, P_DATA_WIDTH bits: the buffer head word.
REQ-011 The block SHALL have port i_ready, input, 1 bit: the consumer accepts the head word.
REQ-012 The block SHALL have port o_count, output, clog2(P_DEPTH)+1 bits: the number of words stored.
REQ-013 The block SHALL have port o_full, output, 1 bit: o_count == P_DEPTH.
REQ-014 The block SHALL have port o_overflow, output, 1 bit: sticky flag that is set when a word is dropped.
REQ-015 The block SHALL have port i_clr_ovf, input, 1 bit: clears o_overflow.

Function
REQ-016 A capture event in mode "DATA_VALID-1" SHALL be any cycle where i_valid is 1.
REQ-017 A capture event in mode "DATA_VALID-ALIGN" SHALL be a rising edge only: i_valid is 1 and the registered previous i_valid (r_valid_d) is 0; one event per assertion, regardless of its length.
REQ-018 On a capture event, i_data SHALL be sampled in the same cycle as the event.
REQ-019 A push SHALL occur when there is a capture event and either the buffer is not full or a pop occurs in the same cycle.
REQ-020 A pop SHALL occur when o_valid and i_ready are both 1; o_valid and o_data SHALL be first-word-fall-through, so o_data equals the oldest stored word whenever o_valid is 1.
REQ-021 Latency SHALL be 1 cycle: a word captured at clock edge N SHALL show o_valid=1 and o_data equal to that word after edge N when the buffer was empty.
REQ-022 Ordering SHALL be strict FIFO; the write and read pointers SHALL wrap from P_DEPTH-1 to 0.
REQ-023 Simultaneous push and pop when empty SHALL NOT bypass: the pop is impossible because o_valid=0; the push is stored and o_count becomes 1.
REQ-024 Simultaneous push and pop when not empty SHALL accept both; o_count SHALL be unchanged.
REQ-025 Simultaneous push and pop when full SHALL accept both; o_count SHALL stay at P_DEPTH and no overflow SHALL be flagged.
REQ-026 A capture event when full with no pop SHALL drop the word, leave the buffer contents and o_count unchanged, and set o_overflow to 1 on the next cycle.
REQ-027 o_overflow SHALL remain 1 until i_clr_ovf=1; if i_clr_ovf and a new drop occur in the same cycle, the drop SHALL win and o_overflow SHALL stay 1.
REQ-028 o_valid SHALL equal (o_count != 0).
REQ-029 o_full SHALL equal (o_count == P_DEPTH).
REQ-030 All outputs except o_data SHALL be registered or be pure decodes of registered state.
REQ-031 The block SHALL NOT apply backpressure upstream: the CDC DMUX has no ready signal, so the only loss indication is o_overflow.

Reset
REQ-032 While i_rst=1 at a clock edge, the block SHALL set: o_count=0, o_valid=0, o_full=0, o_overflow=0, pointers=0, r_valid_d=1.
REQ-033 o_data during and after reset SHALL be don't-care while o_valid=0; memory contents SHALL NOT be reset.
REQ-034 Because r_valid_d resets to 1, in ALIGN mode an i_valid level that was already high across reset release SHALL NOT be captured; the next rising edge SHALL be captured.
REQ-035 Reset asserted mid-operation SHALL discard all stored words, and o_valid SHALL be 0 in the cycle after the reset edge.

Verification
REQ-036 ALIGN mode, i_valid high for 20 cycles with i_data=16'h5A5A, i_ready=0 -> exactly one word stored; o_count=1; o_data=16'h5A5A.
REQ-037 Mode "DATA_VALID-1", 3 one-cycle pulses with data 16'h0001, 16'h0002, 16'h0003, then i_ready=1 -> o_data sequence 0001, 0002, 0003; o_count returns to 0.
REQ-038 P_DEPTH=4, i_ready=0, 5 capture events with data 1..5 -> o_full=1 and o_overflow=1; the read-out sequence is 1, 2, 3, 4 and word 5 is lost.
REQ-039 Full buffer, capture event with i_ready=1 in the same cycle -> o_count stays 4, o_overflow stays 0, and the new word is read last.
REQ-040 i_rst pulsed for 1 cycle with o_count=3 and i_valid held high (ALIGN mode) -> o_count=0 and o_valid=0; no capture occurs until i_valid falls and rises again.
REQ-041 Overflow set, then i_clr_ovf=1 for 1 cycle with no event -> o_overflow=0; i_clr_ovf=1 coinciding with a drop -> o_overflow stays 1.
